// File: rtl/arith_seq.sv
// Command sequencer in front of the shared 32-bit adder: ADD/SUB/CMP in one
// adder cycle, MUL as a WIDTH-step shift-add loop through the same adder.
module arith_seq #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n
);
    localparam int CW = $clog2(MUL_ITERS);
    localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL_LOOP, RESP} state_t;
    typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_SUB, CMD_CMP, CMD_MUL} cmd_t;
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             z;
        logic             v;
        logic             n;
    } rsp_t;

    state_t           state;
    cmd_t             cmd_q;
    rsp_t             rsp_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;   // also holds operand A for single-cycle ops
    logic [WIDTH-1:0] mplier;  // also holds operand B for single-cycle ops
    logic [CW-1:0]    cnt;

    assign req_ready  = (state == IDLE) && !reset;
    assign rsp_valid  = (state == RESP);
    assign rsp_result = rsp_q.result;
    assign rsp_z      = rsp_q.z;
    assign rsp_v      = rsp_q.v;
    assign rsp_n      = rsp_q.n;

    // Adder port decode from registered state; idle adder sees all zeros.
    always_comb begin
        alu_op = 2'b00;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            EXEC: begin
                alu_op = (cmd_q == CMD_ADD) ? 2'b00 : 2'b01;
                alu_a  = mcand;
                alu_b  = mplier;
            end
            MUL_LOOP: begin
                alu_a = acc;
                alu_b = mplier[0] ? mcand : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cmd_q  <= CMD_ADD;
            rsp_q  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_q  <= cmd_t'(req_cmd);
                        mcand  <= req_a;
                        mplier <= req_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= (cmd_t'(req_cmd) == CMD_MUL) ? MUL_LOOP : EXEC;
                    end
                end
                EXEC: begin
                    rsp_q.result <= (cmd_q == CMD_CMP) ? '0 : alu_out;
                    rsp_q.z      <= alu_z;
                    rsp_q.v      <= alu_v;
                    rsp_q.n      <= alu_n;
                    state        <= RESP;
                end
                MUL_LOOP: begin
                    acc    <= alu_out;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // Fixed iteration count: the low product bits are final only here.
                    if (cnt == LAST) begin
                        rsp_q.result <= alu_out;
                        rsp_q.z      <= alu_z;
                        rsp_q.v      <= 1'b0;
                        rsp_q.n      <= alu_n;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
